// File: rtl/tlc5955_gs_buffer.sv
// Double-banked grayscale frame store feeding tlc5955_spi: random writes land in the back
// bank, a swap promotes it to the front bank and streams it out in daisy-chain shift order.
module tlc5955_gs_buffer #(
    parameter int DaisyChain = 2,
    parameter int AddrWidth  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [15:0]          wr_data,
    input  logic                 swap,
    output logic                 swap_pending,
    output logic                 front_bank,
    output logic                 spi_transfer,
    input  logic                 spi_busy,
    input  logic                 next_data,
    output logic [15:0]          data_out,
    output logic                 underrun
);
    localparam int Words = 48 * DaisyChain;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Words - 1);

    typedef enum logic [1:0] {IDLE, ARM, STREAM} state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 start;
    logic                 active;
    logic                 drained;
    logic                 pop;
    logic                 last_pop;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth-1:0] rd_addr;
    logic [15:0]          ram [2][Words];

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (swap_pending || swap) begin
                    start   = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (spi_busy) state_d = STREAM;
            end
            STREAM: begin
                if (!spi_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The read address looks one word ahead on next_data so the following word is
    // already on data_out in the cycle right after the pop.
    always_comb begin
        active   = (state_q != IDLE);
        pop      = next_data && active && !drained;
        last_pop = pop && (rd_ptr == '0);
        rd_addr  = rd_ptr;
        if (pop && !last_pop) rd_addr = rd_ptr - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LastAddr)) begin
            ram[~front_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
            spi_transfer <= 1'b0;
            underrun     <= 1'b0;
            rd_ptr       <= LastAddr;
            drained      <= 1'b0;
            data_out     <= '0;
        end else begin
            state_q      <= state_d;
            spi_transfer <= start;
            if (start) begin
                front_bank   <= ~front_bank;
                swap_pending <= 1'b0;
                rd_ptr       <= LastAddr;
                drained      <= 1'b0;
            end else begin
                if (swap) swap_pending <= 1'b1;
                if (pop) begin
                    if (last_pop) drained <= 1'b1;
                    else          rd_ptr  <= rd_ptr - 1'b1;
                end
            end
            // Popping past the last word, or any pop outside a transfer, is a consumer error.
            if (next_data && (!active || drained)) underrun <= 1'b1;
            if (!active || drained || last_pop) data_out <= '0;
            else                                data_out <= ram[front_bank][rd_addr];
        end
    end

endmodule

// File: tb/tb_tlc5955_gs_buffer.sv
// Bench for tlc5955_gs_buffer: plays the tlc5955_spi side and checks every streamed word
// against a two-bank frame model fed by the same writes and swaps.
module tb_tlc5955_gs_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        swap = 1'b0;
    logic        swap_pending;
    logic        front_bank;
    logic        spi_transfer;
    logic        spi_busy = 1'b0;
    logic        next_data = 1'b0;
    logic [15:0] data_out;
    logic        underrun;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] model_mem [2][96];
    logic [15:0] exp_frame [96];
    bit          model_front = 1'b0;

    tlc5955_gs_buffer #(.DaisyChain(2), .AddrWidth(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap         (swap),
        .swap_pending (swap_pending),
        .front_bank   (front_bank),
        .spi_transfer (spi_transfer),
        .spi_busy     (spi_busy),
        .next_data    (next_data),
        .data_out     (data_out),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock; writes land in the model's back bank, then single-cycle pulses drop.
    task automatic tick();
        bit back;
        @(posedge clk);
        #1;
        back = ~model_front;
        if (wr_en && !reset && wr_addr < 7'd96) model_mem[back][wr_addr] = wr_data;
        wr_en     = 1'b0;
        swap      = 1'b0;
        next_data = 1'b0;
    endtask

    task automatic write_word(input logic [6:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
    endtask

    task automatic rand_write_slot();
        if ($urandom_range(1, 0) == 1) begin
            wr_en   = 1'b1;
            wr_addr = 7'($urandom_range(127, 0));
            wr_data = 16'($urandom);
        end
    endtask

    // Called in the cycle where the transfer pulse must be visible.
    task automatic started(input string tag);
        model_front = ~model_front;
        for (int i = 0; i < 96; i++) exp_frame[i] = model_mem[model_front][i];
        chk({tag, "_xfer"}, 16'(spi_transfer), 16'd1);
        chk({tag, "_front"}, 16'(front_bank), 16'(model_front));
        chk({tag, "_pend_clr"}, 16'(swap_pending), 16'd0);
    endtask

    task automatic stream(input string tag, input int n_next, input bit ffff_fill,
                          input bit extra_swaps, input bit rand_wr);
        int wa = 0;
        spi_busy = 1'b1;
        tick();
        chk({tag, "_pulse_len"}, 16'(spi_transfer), 16'd0);
        tick();
        chk({tag, "_first"}, data_out, exp_frame[95]);
        for (int k = 0; k < n_next; k++) begin
            next_data = 1'b1;
            if (extra_swaps && (k == 10 || k == 30 || k == 50)) swap = 1'b1;
            if (ffff_fill && wa < 96) begin
                wr_en = 1'b1; wr_addr = 7'(wa); wr_data = 16'hFFFF; wa++;
            end else if (rand_wr) rand_write_slot();
            tick();
            if (k < 95)       chk({tag, "_word"}, data_out, exp_frame[94 - k]);
            else if (k == 95) chk({tag, "_no_underrun"}, 16'(underrun), 16'd0);
            else begin
                chk({tag, "_underrun"}, 16'(underrun), 16'd1);
                chk({tag, "_under_data"}, data_out, 16'h0000);
            end
            if (extra_swaps && k == 50) chk({tag, "_pend_set"}, 16'(swap_pending), 16'd1);
            if (ffff_fill && wa < 96) begin
                wr_en = 1'b1; wr_addr = 7'(wa); wr_data = 16'hFFFF; wa++;
            end else if (rand_wr) rand_write_slot();
            tick();
        end
    endtask

    task automatic end_frame(input string tag, input bit expect_next);
        spi_busy = 1'b0;
        tick();
        chk({tag, "_gap"}, 16'(spi_transfer), 16'd0);
        tick();
        if (expect_next) started({tag, "_next"});
        else begin
            chk({tag, "_no_next"}, 16'(spi_transfer), 16'd0);
            chk({tag, "_pend_idle"}, 16'(swap_pending), 16'd0);
        end
    endtask

    task automatic do_swap(input string tag);
        swap = 1'b1;
        tick();
        started(tag);
    endtask

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_xfer", 16'(spi_transfer), 16'd0);
        chk("rst_front", 16'(front_bank), 16'd0);
        chk("rst_pend", 16'(swap_pending), 16'd0);
        chk("rst_data", data_out, 16'h0000);
        chk("rst_under", 16'(underrun), 16'd0);
        reset = 1'b0;
        tick();

        // Frame A: ramp, with three merged swaps and an FFFF rewrite of the back bank
        for (int i = 0; i < 96; i++) write_word(7'(i), 16'(16'h1000 + i));
        do_swap("A");
        chk("A_ramp_top", exp_frame[95], 16'h105F);
        stream("A", 96, 1'b1, 1'b1, 1'b0);
        end_frame("A", 1'b1);

        // Frame B: started automatically from the pending swap, all FFFF
        stream("B", 96, 1'b0, 1'b0, 1'b0);
        end_frame("B", 1'b0);

        // Frame C: random contents, out-of-range write, write coinciding with swap
        for (int i = 0; i < 96; i++) write_word(7'(i), 16'($urandom));
        write_word(7'd100, 16'h5A5A);
        wr_en = 1'b1; wr_addr = 7'd5; wr_data = 16'hABCD;
        do_swap("C");
        stream("C", 96, 1'b0, 1'b0, 1'b1);
        end_frame("C", 1'b0);

        // Randomized frames with scattered writes before and during the transfer
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 40; j++) write_word(7'($urandom_range(127, 0)), 16'($urandom));
            do_swap("R");
            stream("R", 96, 1'b0, 1'b0, 1'b1);
            end_frame("R", 1'b0);
        end

        // Underrun: one next_data beyond the frame, flag sticks after the transfer
        do_swap("U");
        stream("U", 97, 1'b0, 1'b0, 1'b0);
        end_frame("U", 1'b0);
        tick();
        chk("U_sticky", 16'(underrun), 16'd1);

        // Reset in the middle of a stream with a swap pending
        do_swap("S");
        stream("S", 10, 1'b0, 1'b0, 1'b0);
        swap = 1'b1;
        tick();
        chk("S_pend", 16'(swap_pending), 16'd1);
        reset = 1'b1;
        spi_busy = 1'b0;
        tick();
        reset = 1'b0;
        model_front = 1'b0;
        chk("S_rst_xfer", 16'(spi_transfer), 16'd0);
        chk("S_rst_front", 16'(front_bank), 16'd0);
        chk("S_rst_pend", 16'(swap_pending), 16'd0);
        chk("S_rst_under", 16'(underrun), 16'd0);
        chk("S_rst_data", data_out, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("S_quiet", 16'(spi_transfer), 16'd0);
        end
        do_swap("P");
        stream("P", 96, 1'b0, 1'b0, 1'b1);
        end_frame("P", 1'b0);

        // next_data while idle is also an underrun
        chk("I_under_before", 16'(underrun), 16'd0);
        next_data = 1'b1;
        tick();
        chk("I_under_after", 16'(underrun), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
